// File: rtl/scsi_io_arbiter.sv
// ---------------------------------------------------------------------------
// scsi_io_arbiter
//
// Shares one host block-I/O channel between two SCSI target instances.
// Requests are one 512-byte block each and are granted one at a time with
// round-robin fairness. Once a request is granted, its LBA and operation are
// latched. The owner's index is reported on sd_dev so the host selects the
// correct disk image. The ack and buffer write strobes are steered to the
// owner only.
//
// Optional feature (compile-time macro SCSI_ARB_TIMEOUT_EN):
//   When the macro is defined, a watchdog abandons a request that the host
//   has not acknowledged within TIMEOUT cycles of ISSUE. It also sets the
//   sticky arb_err flag. When the macro is undefined, no counter is built,
//   arb_err is tied low, and ISSUE waits for the host indefinitely.
//
// Ports
//   clk                     system clock, all logic on the rising edge
//   reset                   asynchronous, active-high reset
//   t0_io_lba / t1_io_lba   block address from target 0 / 1
//   t0_io_rd  / t1_io_rd    level read request, held until io_ack
//   t0_io_wr  / t1_io_wr    level write request, held until io_ack
//   t0_io_ack / t1_io_ack   ack to target 0 / 1
//   t0_buff_din/t1_buff_din target outbound buffer data (write path)
//   t0_buff_wr/t1_buff_wr   buffer write strobe to target 0 / 1
//   sd_lba                  latched LBA of the granted request
//   sd_rd / sd_wr           host request strobes
//   sd_dev                  index of the owning target
//   sd_ack                  host busy/ack, high for the whole transfer
//   sd_buff_wr              host buffer write strobe
//   sd_buff_din             owner's buffer data to the host
//   arb_err                 sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module scsi_io_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd4_000_000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] t0_io_lba,
    input  logic        t0_io_rd,
    input  logic        t0_io_wr,
    output logic        t0_io_ack,
    input  logic [15:0] t0_buff_din,
    output logic        t0_buff_wr,

    input  logic [31:0] t1_io_lba,
    input  logic        t1_io_rd,
    input  logic        t1_io_wr,
    output logic        t1_io_ack,
    input  logic [15:0] t1_buff_din,
    output logic        t1_buff_wr,

    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        sd_dev,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [15:0] sd_buff_din,

    output logic        arb_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_XFER    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]  state;
    logic        owner;
    logic        prio;

    logic        req0;
    logic        req1;
    logic        gnt1;
    logic        gnt_rd;
    logic [31:0] gnt_lba;

    // to_hit: the watchdog expires in this ISSUE cycle.
    // to_pulse: the one-cycle ack that releases the abandoned requester.
    logic        to_hit;
    logic        to_pulse;
    logic        busy_ack;

    // -----------------------------------------------------------------------
    // Grant selection (evaluated every cycle, used only in IDLE)
    // -----------------------------------------------------------------------
    always_comb begin
        req0    = t0_io_rd | t0_io_wr;
        req1    = t1_io_rd | t1_io_wr;
        // Target 1 wins when it is alone, or when both contend and prio
        // points at it.
        gnt1    = req1 & (~req0 | prio);
        // Read has precedence when a target raises both rd and wr.
        gnt_rd  = gnt1 ? t1_io_rd  : t0_io_rd;
        gnt_lba = gnt1 ? t1_io_lba : t0_io_lba;
    end

`ifdef SCSI_ARB_TIMEOUT_EN
    // -----------------------------------------------------------------------
    // Watchdog on the ISSUE phase
    // -----------------------------------------------------------------------
    logic [23:0] to_cnt;
    logic        arb_err_q;

    // The count starts at 0 in the first ISSUE cycle, so hitting TIMEOUT-1
    // means TIMEOUT full ISSUE cycles have passed without an ack.
    assign to_hit = (state == S_ISSUE) && !sd_ack
                    && (to_cnt == TIMEOUT - 24'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt    <= 24'd0;
            to_pulse  <= 1'b0;
            arb_err_q <= 1'b0;
        end else begin
            to_pulse <= to_hit;
            if (to_hit) begin
                arb_err_q <= 1'b1;
            end
            // Cleared in IDLE, so the count is fresh on every entry to ISSUE.
            if (state == S_IDLE) begin
                to_cnt <= 24'd0;
            end else if (state == S_ISSUE) begin
                to_cnt <= to_cnt + 24'd1;
            end
        end
    end

    assign arb_err = arb_err_q;
`else
    // Without the watchdog the limit has no meaning. The parameter is kept so
    // that both builds share one instantiation footprint.
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT;

    assign to_hit   = 1'b0;
    assign to_pulse = 1'b0;
    assign arb_err  = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Ownership FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            owner  <= 1'b0;
            prio   <= 1'b0;
            sd_lba <= 32'd0;
            sd_rd  <= 1'b0;
            sd_wr  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        owner  <= gnt1;
                        sd_lba <= gnt_lba;
                        sd_rd  <= gnt_rd;
                        sd_wr  <= ~gnt_rd;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= S_XFER;
                    end else if (to_hit) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= S_RELEASE;
                    end
                end
                S_XFER: begin
                    if (!sd_ack) begin
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // This state is never a grant opportunity. The owner's
                    // request (possibly still high while the target clears
                    // it) is ignored for one cycle. After that the other
                    // target has priority.
                    prio  <= ~owner;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Owner-steered routing
    // -----------------------------------------------------------------------
    always_comb begin
        busy_ack    = sd_ack & ((state == S_ISSUE) | (state == S_XFER));
        t0_io_ack   = ~owner & (busy_ack | to_pulse);
        t1_io_ack   =  owner & (busy_ack | to_pulse);
        t0_buff_wr  = sd_buff_wr & ~owner & (state == S_XFER);
        t1_buff_wr  = sd_buff_wr &  owner & (state == S_XFER);
        sd_buff_din = owner ? t1_buff_din : t0_buff_din;
        sd_dev      = owner;
    end

endmodule

// File: tb/tb_scsi_io_arbiter.sv
// ---------------------------------------------------------------------------
// tb_scsi_io_arbiter
//
// Directed bench for scsi_io_arbiter. The bench plays both SCSI targets and
// the host. Each request the bench expects to be granted is pushed as
// (dev, lba, op) to a scoreboard queue. The entry is popped and compared when
// the host strobe appears. The bench checks these behaviours:
//   - reset values
//   - single read with 256 buffer pulses
//   - simultaneous requests and grant turnaround
//   - round-robin fairness
//   - write-data mux
//   - LBA changes after grant are ignored
//   - asynchronous reset during a transfer
//   - the watchdog (when built with SCSI_ARB_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module tb_scsi_io_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] t0_io_lba, t1_io_lba;
    logic        t0_io_rd, t0_io_wr, t1_io_rd, t1_io_wr;
    logic        t0_io_ack, t1_io_ack;
    logic [15:0] t0_buff_din, t1_buff_din;
    logic        t0_buff_wr, t1_buff_wr;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_dev;
    logic        sd_ack, sd_buff_wr;
    logic [15:0] sd_buff_din;
    logic        arb_err;

    scsi_io_arbiter #(.TIMEOUT(24'd16)) dut (
        .clk         (clk),
        .reset       (reset),
        .t0_io_lba   (t0_io_lba),
        .t0_io_rd    (t0_io_rd),
        .t0_io_wr    (t0_io_wr),
        .t0_io_ack   (t0_io_ack),
        .t0_buff_din (t0_buff_din),
        .t0_buff_wr  (t0_buff_wr),
        .t1_io_lba   (t1_io_lba),
        .t1_io_rd    (t1_io_rd),
        .t1_io_wr    (t1_io_wr),
        .t1_io_ack   (t1_io_ack),
        .t1_buff_din (t1_buff_din),
        .t1_buff_wr  (t1_buff_wr),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_dev      (sd_dev),
        .sd_ack      (sd_ack),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din),
        .arb_err     (arb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dev;
        logic [31:0] lba;
        logic        rd;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic d, input logic [31:0] l, input logic r);
        exp_t e;
        e.dev = d;
        e.lba = l;
        e.rd  = r;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a host strobe. Then compares it with the oldest
    // scoreboard entry. lat counts the falling edges from the call until the
    // strobe was seen.
    task automatic grant_check(output logic dev, output logic [31:0] lba,
                               output int lat);
        exp_t e;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(sd_rd | sd_wr) && lat < 50);
        check("strobe_seen", 32'(sd_rd | sd_wr), 32'd1);
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        e   = (sb.size() > 0) ? sb.pop_front() : '0;
        dev = e.dev;
        lba = e.lba;
        check("grant_dev", 32'(sd_dev), 32'(e.dev));
        check("grant_lba", sd_lba, e.lba);
        check("grant_rd",  32'(sd_rd), 32'(e.rd));
        check("grant_wr",  32'(sd_wr), 32'(!e.rd));
    endtask

    // Host side of one transfer, starting at the falling edge where the
    // strobe was seen. Targets clear their request on ack. With rearm, the
    // owner raises a fresh read again after the transfer.
    task automatic xfer(input logic dev, input logic [31:0] lba,
                        input int npulses, input logic rearm);
        int c0 = 0;
        int c1 = 0;
        sd_ack = 1'b1;
        #1;
        check("ack_owner", 32'(dev ? t1_io_ack : t0_io_ack), 32'd1);
        check("ack_other", 32'(dev ? t0_io_ack : t1_io_ack), 32'd0);
        if (dev) begin
            t1_io_rd = 1'b0;
            t1_io_wr = 1'b0;
        end else begin
            t0_io_rd = 1'b0;
            t0_io_wr = 1'b0;
        end
        @(negedge clk);
        check("strobe_drop", 32'(sd_rd | sd_wr), 32'd0);
        if (dev) t1_io_lba = 32'hDEAD_0001;
        else     t0_io_lba = 32'hDEAD_0000;
        #1;
        check("buff_din_mux", 32'(sd_buff_din), dev ? 32'hBEEF : 32'h1234);
        for (int i = 0; i < npulses; i++) begin
            @(negedge clk);
            sd_buff_wr = 1'b1;
            #1;
            c0 += int'(t0_buff_wr);
            c1 += int'(t1_buff_wr);
            @(negedge clk);
            sd_buff_wr = 1'b0;
        end
        check("lba_held", sd_lba, lba);
        check("buff_wr_owner", 32'(dev ? c1 : c0), 32'(npulses));
        check("buff_wr_other", 32'(dev ? c0 : c1), 32'd0);
        sd_ack = 1'b0;
        if (rearm) begin
            if (dev) begin
                t1_io_lba = 32'h200;
                t1_io_rd  = 1'b1;
            end else begin
                t0_io_lba = 32'h100;
                t0_io_rd  = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin : stim
        logic        dev;
        logic [31:0] lba;
        int          lat;

        reset       = 1'b1;
        t0_io_lba   = '0;
        t1_io_lba   = '0;
        t0_io_rd    = 1'b0;
        t0_io_wr    = 1'b0;
        t1_io_rd    = 1'b0;
        t1_io_wr    = 1'b0;
        t0_buff_din = 16'h1234;
        t1_buff_din = 16'hBEEF;
        sd_ack      = 1'b0;
        sd_buff_wr  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        check("rst_sd_rd",  32'(sd_rd), 32'd0);
        check("rst_sd_wr",  32'(sd_wr), 32'd0);
        check("rst_sd_lba", sd_lba, 32'd0);
        check("rst_sd_dev", 32'(sd_dev), 32'd0);
        check("rst_arb_err", 32'(arb_err), 32'd0);
        check("rst_acks",   32'({t0_io_ack, t1_io_ack, t0_buff_wr, t1_buff_wr}), 32'd0);

        // Single read from target 0, LBA 0x60, with 256 buffer pulses
        reset = 1'b0;
        @(negedge clk);
        t0_io_lba = 32'h60;
        t0_io_rd  = 1'b1;
        push(1'b0, 32'h60, 1'b1);
        grant_check(dev, lba, lat);
        check("req_latency", 32'(lat), 32'd1);
        xfer(dev, lba, 256, 1'b0);

        // Simultaneous: t0 read LBA 5 and t1 write LBA 9, rising out of reset
        do_reset();
        t0_io_lba = 32'd5;
        t0_io_rd  = 1'b1;
        t1_io_lba = 32'd9;
        t1_io_wr  = 1'b1;
        push(1'b0, 32'd5, 1'b1);
        push(1'b1, 32'd9, 1'b0);
        reset = 1'b0;
        grant_check(dev, lba, lat);
        xfer(dev, lba, 4, 1'b0);
        // Ack fall, then RELEASE, then the IDLE grant. The strobe appears on
        // the third falling edge.
        grant_check(dev, lba, lat);
        check("turnaround", 32'(lat), 32'd3);
        xfer(dev, lba, 4, 1'b0);

        // Fairness: both targets request continuously for 6 transfers
        do_reset();
        t0_io_lba = 32'h100;
        t0_io_rd  = 1'b1;
        t1_io_lba = 32'h200;
        t1_io_rd  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push(k[0], k[0] ? 32'h200 : 32'h100, 1'b1);
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            grant_check(dev, lba, lat);
            xfer(dev, lba, 2, 1'b1);
        end
        t0_io_rd = 1'b0;
        t1_io_rd = 1'b0;
        check("fair_sb_drained", 32'(sb.size()), 32'd0);

        // Async reset during XFER. First serve t0, so that prio points at t1.
        @(negedge clk);
        t0_io_lba = 32'h11;
        t0_io_rd  = 1'b1;
        push(1'b0, 32'h11, 1'b1);
        grant_check(dev, lba, lat);
        xfer(dev, lba, 1, 1'b0);
        t1_io_lba = 32'h22;
        t1_io_rd  = 1'b1;
        push(1'b1, 32'h22, 1'b1);
        grant_check(dev, lba, lat);
        sd_ack = 1'b1;
        @(negedge clk);
        sd_buff_wr = 1'b1;
        #1;
        check("pre_rst_t1_buff_wr", 32'(t1_buff_wr), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("arst_strobes", 32'({sd_rd, sd_wr}), 32'd0);
        check("arst_t1_ack", 32'(t1_io_ack), 32'd0);
        check("arst_t1_buff_wr", 32'(t1_buff_wr), 32'd0);
        check("arst_sd_dev", 32'(sd_dev), 32'd0);
        check("arst_sd_lba", sd_lba, 32'd0);
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        // t1 is still pending. t0 now also requests. With prio reset to 0,
        // t0 is granted first.
        t0_io_lba = 32'h33;
        t0_io_rd  = 1'b1;
        push(1'b0, 32'h33, 1'b1);
        push(1'b1, 32'h22, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        grant_check(dev, lba, lat);
        xfer(dev, lba, 1, 1'b0);
        grant_check(dev, lba, lat);
        xfer(dev, lba, 1, 1'b0);

`ifdef SCSI_ARB_TIMEOUT_EN
        // Watchdog: TIMEOUT=16, the host never acks
        @(negedge clk);
        @(negedge clk);
        t0_io_lba = 32'h44;
        t0_io_rd  = 1'b1;
        lat = 0;
        @(negedge clk);
        while (sd_rd && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        check("to_issue_cycles", 32'(lat), 32'd16);
        check("to_ack_pulse", 32'(t0_io_ack), 32'd1);
        check("to_arb_err", 32'(arb_err), 32'd1);
        t0_io_rd = 1'b0;
        @(negedge clk);
        check("to_ack_one_cycle", 32'(t0_io_ack), 32'd0);
        check("to_arb_err_sticky", 32'(arb_err), 32'd1);
`else
        check("arb_err_tied", 32'(arb_err), 32'd0);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
